// File: rtl/mem_march_bist.sv
// March-style BIST initiator for a single-port RAM: write/read-back of all-zeros
// and all-ones, ascending then descending, latching the first mismatch.
module mem_march_bist #(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 8,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  we,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [1:0]            fail_phase
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_t                state_q, state_d;
  logic [1:0]            phase_q, phase_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  pass_q, pass_d;
  logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
  logic [DATA_WIDTH-1:0] fdata_q, fdata_d;
  logic [1:0]            fphase_q, fphase_d;

  logic [DATA_WIDTH-1:0] pattern;
  logic                  descending;
  logic                  last_addr;
  logic                  mismatch;
  logic [1:0]            phase_inc;

  // Phases 0/2 write zeros, 1/3 write ones; phases 2/3 walk downward.
  assign pattern    = {DATA_WIDTH{phase_q[0]}};
  assign descending = phase_q[1];
  assign last_addr  = descending ? (addr_q == '0) : (addr_q == LAST_ADDR);
  assign phase_inc  = phase_q + 2'd1;
  // Case inequality so that X/Z on the bus counts as a failure in simulation.
  assign mismatch   = (data !== pattern);

  assign address    = addr_q;
  assign we         = (state_q == WRITE);
  assign data       = we ? pattern : {DATA_WIDTH{1'bz}};
  assign busy       = (state_q == WRITE) || (state_q == READ) || (state_q == CHECK);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign fail_addr  = faddr_q;
  assign fail_data  = fdata_q;
  assign fail_phase = fphase_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      addr_q   <= '0;
      pass_q   <= 1'b0;
      faddr_q  <= '0;
      fdata_q  <= '0;
      fphase_q <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      addr_q   <= addr_d;
      pass_q   <= pass_d;
      faddr_q  <= faddr_d;
      fdata_q  <= fdata_d;
      fphase_q <= fphase_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    addr_d   = addr_q;
    pass_d   = pass_q;
    faddr_d  = faddr_q;
    fdata_d  = fdata_q;
    fphase_d = fphase_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = WRITE;
          phase_d  = '0;
          addr_d   = '0;
          pass_d   = 1'b0;
          faddr_d  = '0;
          fdata_d  = '0;
          fphase_d = '0;
        end
      end
      WRITE: state_d = READ;
      READ:  state_d = CHECK;
      CHECK: begin
        if (mismatch) begin
          state_d  = DONE;
          pass_d   = 1'b0;
          faddr_d  = addr_q;
          fdata_d  = data;
          fphase_d = phase_q;
        end else if (!last_addr) begin
          state_d = WRITE;
          addr_d  = descending ? addr_q - 1'b1 : addr_q + 1'b1;
        end else if (phase_q == 2'd3) begin
          state_d = DONE;
          pass_d  = 1'b1;
        end else begin
          state_d = WRITE;
          phase_d = phase_inc;
          addr_d  = phase_inc[1] ? LAST_ADDR : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/mem_march_bist.md
Name: mem_march_bist

Overview:
Built-in self-test initiator for the single-port RAM (`mem`). It drives the RAM's `address`, `we` and shared bidirectional `data` bus, and runs a four-phase march test: write then read-back of all-zeros and all-ones, in ascending and then descending address order. It compares each read against the expected pattern and latches the first failure. It sits between the RAM and system test control, replacing bench-driven stimulus on silicon.

Parameters:
DATA_WIDTH, 8, width of RAM data bus
RAM_DEPTH, 8, number of RAM words
ADDR_WIDTH, $clog2(RAM_DEPTH), RAM address width

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  begin test; sampled in IDLE or DONE
address  output  ADDR_WIDTH  RAM address
we  output  1  RAM write enable (1 = write, 0 = read)
data  inout  DATA_WIDTH  shared RAM data bus; driven by this block only while we=1, else high-Z
busy  output  1  test in progress
done  output  1  test finished; held until next start or rst
pass  output  1  valid when done=1; 1 = no mismatch
fail_addr  output  ADDR_WIDTH  address of first mismatch
fail_data  output  DATA_WIDTH  value read at first mismatch
fail_phase  output  2  phase of first mismatch (0..3)

Behaviour:
- Reset values (next rising edge with rst=1): state=IDLE, we=0, data=Z, address=0, busy=0, done=0, pass=0, fail_addr=0, fail_data=0, fail_phase=0. rst has priority over all inputs.
- States: IDLE, WRITE, READ, CHECK, DONE. Internal phase counter (2 bits) and address counter.
- Phases: 0 = pattern 0x00 ascending; 1 = all-ones ascending; 2 = all-zeros descending; 3 = all-ones descending. Pattern width = DATA_WIDTH. Ascending runs 0..RAM_DEPTH-1; descending runs RAM_DEPTH-1..0.
- IDLE/DONE + start=1: next cycle enters WRITE with phase=0, address=0. Entering from DONE clears done, pass and the fail_* registers.
- WRITE (1 cycle): we=1, data=pattern, address=current.
- READ (1 cycle): we=0, data=Z, address held.
- CHECK (1 cycle): we=0, address held. data is sampled at the rising edge ending this cycle. This tolerates either async-read or 1-cycle-latency RAM reads.
- Compare: any bit differing from the pattern is a mismatch, including X/Z in simulation. On mismatch, latch fail_addr=address, fail_data=sampled value, fail_phase=phase. Then go to DONE with pass=0 and stop; there is no further RAM access.
- No mismatch, not the last address of the phase: step the address (+1 ascending, -1 descending) and return to WRITE.
- Last address of the phase: if phase<3, go to phase+1 and WRITE at that phase's start address. If phase=3, go to DONE with pass=1.
- Timing: the edge that samples start ends cycle 0.
  - busy=1 from cycle 1 through the final CHECK.
  - Full passing run is 4*3*RAM_DEPTH cycles (96 for default), so done=1 is first visible in cycle 97.
  - busy=0 whenever done=1.
- start while busy=1 is ignored.
- DONE holds all outputs and fail registers stable; we=0, data=Z.
- rst mid-run: at the next edge we=0 and data=Z. The in-flight WRITE cycle may complete in the RAM; no further writes occur. Results are cleared.
- address changes only on rising edges, so it is stable for the whole we=1 cycle.

Test Plan:
1. Fault-free RAM, default params, start pulse:
   - Cycles 1-3 show address=0 with we=1,0,0 and data=0x00 in cycle 1; cycle 4 shows address=1 with we=1.
   - Cycle 49 shows address=7 with we=1 and data=0x00 (phase 2 start).
   - done=1, pass=1, busy=0 in cycle 97.
2. Bit 0 of address 5 stuck-at-1, start -> done in cycle 19 with pass=0, fail_addr=5, fail_data=0x01, fail_phase=0; no we=1 after cycle 16.
3. Bit 7 of address 2 stuck-at-0 -> pass=0, fail_addr=2, fail_data=0x7F, fail_phase=1, done in cycle 34.
4. Assert rst in cycle 40 -> next cycle we=0, data=Z, busy=0, done=0. A following start gives a full pass in 96 cycles.
5. start pulsed during busy (cycle 10) -> ignored, run ends in cycle 97. start pulsed in DONE after a failing run -> fail_* cleared, new run passes.
6. RAM_DEPTH=16 -> full pass in 192 cycles; phase 2 begins at address 15.
